leds_ctrl: RTL and testbench



---
 rtl/leds_ctrl_pkg.sv | 19 +
 rtl/leds_ctrl_tick_gen.sv | 36 +++
 rtl/leds_ctrl.sv | 164 ++++++++++++++++
 tb/tb_leds_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/leds_ctrl_pkg.sv
// leds_ctrl shared definitions
// mode encodings and register map
package leds_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_SW     = 2'd0,
    MODE_METER  = 2'd1,
    MODE_SCROLL = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int STATUS_TICK_BIT = 8;

endpackage

// File: rtl/leds_ctrl_tick_gen.sv
// leds_tick_gen: animation/decay prescaler
// down-counter, one-cycle tick at zero
module leds_tick_gen #(
  parameter int PERIOD_W       = 24,
  parameter int DEFAULT_PERIOD = 5000000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PERIOD_W-1:0] period,
  input  logic                reload,
  output logic                tick
);

  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] load_val;

  // period 0 behaves like period 1
  always_comb begin
    load_val = '0;
    if (period != '0)
      load_val = period - PERIOD_W'(1);
  end

  assign tick = (cnt == '0) && !reload;

  // count down, reload on zero or on request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt <= PERIOD_W'(DEFAULT_PERIOD - 1);
    else if (reload || cnt == '0)
      cnt <= load_val;
    else
      cnt <= cnt - PERIOD_W'(1);
  end

endmodule

// File: rtl/leds_ctrl.sv
// leds_ctrl: Avalon-MM LED sequencer
// sw pattern, level meter, scroll, blink
module leds_ctrl
  import leds_ctrl_pkg::*;
#(
  parameter int LED_W          = 8,
  parameter int PERIOD_W       = 24,
  parameter int DEFAULT_PERIOD = 5000000,
  parameter int DECAY_HOLD     = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [3:0]       meter_level,
  input  logic             meter_valid,
  output logic [LED_W-1:0] out_port
);

  logic [LED_W-1:0]    data_q;
  mode_e               mode_q;
  logic [PERIOD_W-1:0] period_q;
  logic [3:0]          peak_q;
  logic [3:0]          hold_q;
  logic [LED_W-1:0]    pat_q;
  logic                phase_q;
  logic                tick_seen_q;

  logic wr, wr_data, wr_ctrl, wr_period, wr_status;
  logic tick;
  mode_e new_mode;
  logic [PERIOD_W-1:0] period_ld;
  logic [3:0] lvl_sat;
  logic [LED_W-1:0] therm;
  logic [LED_W-1:0] out_nxt;
  logic unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wr_data   = wr && address == ADDR_DATA;
  assign wr_ctrl   = wr && address == ADDR_CTRL;
  assign wr_period = wr && address == ADDR_PERIOD;
  assign wr_status = wr && address == ADDR_STATUS;
  assign new_mode  = mode_e'(writedata[1:0]);
  assign unused_wd = ^writedata;

  assign period_ld = wr_period ? writedata[PERIOD_W-1:0]
                               : period_q;

  assign lvl_sat = (meter_level > 4'(LED_W)) ? 4'(LED_W)
                                             : meter_level;

  leds_tick_gen #(
    .PERIOD_W       (PERIOD_W),
    .DEFAULT_PERIOD (DEFAULT_PERIOD)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .period  (period_ld),
    .reload  (wr_period | wr_ctrl),
    .tick    (tick)
  );

  // software-visible registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q      <= '0;
      mode_q      <= MODE_SW;
      period_q    <= PERIOD_W'(DEFAULT_PERIOD);
      tick_seen_q <= 1'b0;
    end else begin
      if (wr_data)   data_q   <= writedata[LED_W-1:0];
      if (wr_ctrl)   mode_q   <= new_mode;
      if (wr_period) period_q <= writedata[PERIOD_W-1:0];
      if (tick)
        tick_seen_q <= 1'b1;
      else if (wr_status && writedata[STATUS_TICK_BIT])
        tick_seen_q <= 1'b0;
    end
  end

  // meter peak capture with hold then decay
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      peak_q <= '0;
      hold_q <= '0;
    end else if (meter_valid) begin
      peak_q <= lvl_sat;
      hold_q <= 4'(DECAY_HOLD);
    end else if (tick) begin
      if (hold_q != '0)
        hold_q <= hold_q - 4'd1;
      else if (peak_q != '0)
        peak_q <= peak_q - 4'd1;
    end
  end

  // scroll pattern and blink phase
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pat_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      if (wr_ctrl && new_mode == MODE_SCROLL
          && mode_q != MODE_SCROLL)
        pat_q <= data_q;
      else if (wr_data && mode_q == MODE_SCROLL)
        pat_q <= writedata[LED_W-1:0];
      else if (tick && mode_q == MODE_SCROLL)
        pat_q <= {pat_q[LED_W-2:0], pat_q[LED_W-1]};

      if (wr_ctrl && new_mode == MODE_BLINK
          && mode_q != MODE_BLINK)
        phase_q <= 1'b1;
      else if (tick && mode_q == MODE_BLINK)
        phase_q <= ~phase_q;
    end
  end

  // thermometer code of the peak
  always_comb begin
    therm = '0;
    for (int i = 0; i < LED_W; i++)
      therm[i] = (i < int'(peak_q));
  end

  // LED source select
  always_comb begin
    out_nxt = '0;
    unique case (mode_q)
      MODE_SW:     out_nxt = data_q;
      MODE_METER:  out_nxt = therm;
      MODE_SCROLL: out_nxt = pat_q;
      MODE_BLINK:  out_nxt = phase_q ? data_q : '0;
      default:     out_nxt = '0;
    endcase
  end

  // registered LED drive
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      out_port <= '0;
    else
      out_port <= out_nxt;
  end

  // combinational read mux
  always_comb begin
    readdata = '0;
    unique case (address)
      ADDR_DATA:   readdata[LED_W-1:0] = data_q;
      ADDR_CTRL:   readdata[1:0] = mode_q;
      ADDR_PERIOD: readdata[PERIOD_W-1:0] = period_q;
      ADDR_STATUS: begin
        readdata[3:0] = peak_q;
        readdata[STATUS_TICK_BIT] = tick_seen_q;
      end
      default:     readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_leds_ctrl.sv
// tb_leds_ctrl: self-checking bench
// expected LED values queued, drained per cycle
module tb_leds_ctrl;
  import leds_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [3:0]  meter_level = '0;
  logic        meter_valid = 1'b0;
  logic [7:0]  out_port;

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rv;

  leds_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .address     (address),
    .chipselect  (chipselect),
    .write_n     (write_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .meter_level (meter_level),
    .meter_valid (meter_valid),
    .out_port    (out_port)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d);
    @(negedge clk);
    address = a;
    chipselect = 1'b1;
    write_n = 1'b0;
    writedata = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic rd(logic [1:0] a, output logic [31:0] d);
    address = a;
    chipselect = 1'b1;
    #1;
    d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic pulse(logic [3:0] lvl);
    @(negedge clk);
    meter_level = lvl;
    meter_valid = 1'b1;
    @(negedge clk);
    meter_valid = 1'b0;
  endtask

  task automatic drain(string tag, int step);
    int gap;
    gap = 1;
    while (exp_q.size() > 0) begin
      repeat (gap) @(negedge clk);
      chk(tag, {24'd0, out_port}, exp_q.pop_front());
      gap = step;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    rd(ADDR_DATA, rv);   chk("rst_data", rv, 32'd0);
    rd(ADDR_CTRL, rv);   chk("rst_ctrl", rv, 32'd0);
    rd(ADDR_PERIOD, rv); chk("rst_period", rv, 32'd5000000);
    rd(ADDR_STATUS, rv); chk("rst_status", rv, 32'd0);
    chk("rst_out", {24'd0, out_port}, 32'd0);

    wr(ADDR_DATA, 32'hA5);
    chk("sw_latency", {24'd0, out_port}, 32'd0);
    exp_q.push_back(32'hA5);
    drain("sw_out", 1);
    rd(ADDR_DATA, rv);   chk("sw_readback", rv, 32'hA5);

    wr(ADDR_PERIOD, 32'd3);
    wr(ADDR_DATA, 32'h81);
    wr(ADDR_CTRL, 32'd2);
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q.push_back(32'h81); exp_q.push_back(32'h03);
    exp_q.push_back(32'h06); exp_q.push_back(32'h0C);
    exp_q.push_back(32'h18); exp_q.push_back(32'h30);
    exp_q.push_back(32'h60); exp_q.push_back(32'hC0);
    exp_q.push_back(32'h81); exp_q.push_back(32'h03);
    drain("scroll", 3);

    wr(ADDR_DATA, 32'h0F);
    wr(ADDR_PERIOD, 32'd2);
    wr(ADDR_CTRL, 32'd3);
    exp_q.push_back(32'h0F); exp_q.push_back(32'h00);
    exp_q.push_back(32'h0F); exp_q.push_back(32'h00);
    exp_q.push_back(32'h0F);
    drain("blink", 2);

    wr(ADDR_CTRL, 32'd1);
    wr(ADDR_PERIOD, 32'd1);
    pulse(4'd11);
    repeat (5) exp_q.push_back(32'hFF);
    exp_q.push_back(32'h7F); exp_q.push_back(32'h3F);
    exp_q.push_back(32'h1F); exp_q.push_back(32'h0F);
    exp_q.push_back(32'h07); exp_q.push_back(32'h03);
    exp_q.push_back(32'h01); exp_q.push_back(32'h00);
    drain("meter_decay", 1);

    pulse(4'd2);
    exp_q.push_back(32'h03);
    drain("meter_vs_tick", 1);
    rd(ADDR_STATUS, rv); chk("status_peak", rv, 32'h102);

    wr(ADDR_PERIOD, 32'd0);
    wr(ADDR_STATUS, 32'h100);
    rd(ADDR_STATUS, rv);
    chk("tick_set_wins", rv & 32'h100, 32'h100);
    wr(ADDR_PERIOD, 32'd1000);
    wr(ADDR_STATUS, 32'h100);
    rd(ADDR_STATUS, rv);
    chk("tick_clear", rv & 32'h100, 32'h0);
    rd(ADDR_PERIOD, rv); chk("period_rb", rv, 32'd1000);

    wr(ADDR_DATA, 32'h81);
    wr(ADDR_PERIOD, 32'd3);
    wr(ADDR_CTRL, 32'd2);
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk("rst_async_out", {24'd0, out_port}, 32'd0);
    rd(ADDR_DATA, rv);   chk("rst2_data", rv, 32'd0);
    rd(ADDR_CTRL, rv);   chk("rst2_ctrl", rv, 32'd0);
    rd(ADDR_PERIOD, rv); chk("rst2_period", rv, 32'd5000000);
    rd(ADDR_STATUS, rv); chk("rst2_status", rv, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst2_out_held", {24'd0, out_port}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
